shift_mix_stage: RTL and testbench
==================================

// Module: shift_mix_stage
// PURPOSE
//  AES round datapath stage directly downstream of sbox: applies ShiftRows then MixColumns to the
//  128-bit SubBytes result. For the final round, it applies ShiftRows only. Output feeds AddRoundKey.
//  Registered, 1-cycle latency, full-throughput valid/ready pipeline with a 1-entry skid buffer so that
//  in_ready is a pure register output. A TAG sideband travels with each block and is not modified.
// PARAMETERS
//  TAG_W   4   width of sideband tag (round index / CTR slot id), passed through unchanged
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  flush      in   1      synchronous; drops all held blocks
//  in_valid   in   1      s_in/in_last/in_tag valid
//  in_ready   out  1      stage can accept; registered
//  s_in       in   128    SubBytes output; byte0 = [127:120], column c = bytes 4c..4c+3, row r = byte 4c+r
//  in_last    in   1      1 = final round: skip MixColumns
//  in_tag     in   TAG_W  sideband
//  out_valid  out  1      m_o/out_tag valid
//  out_ready  in   1      downstream accepts
//  m_o        out  128    transformed state, same byte order as s_in
//  out_tag    out  TAG_W  tag of the block on m_o
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, in_ready=1, skid empty, m_o=0, out_tag=0.
//  - Transform: ShiftRows out byte[4c+r] = in byte[4((c+r)%4)+r]. MixColumns per column over GF(2^8),
//    poly 0x11B: [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2]. It is applied when in_last=0.
//    The transform is computed combinationally on s_in and registered.
//  - Handshake: a transfer occurs when valid&ready. The producer must hold data stable while
//    valid&!ready. in_valid must not depend on in_ready.
//  - Output register (OR) and skid register (SK) each have a valid bit. Latency is 1 cycle from input
//    transfer to out_valid.
//  - Accept with OR empty or out_ready=1: the transformed block loads into OR.
//  - Accept with OR full and out_ready=0: the block loads into SK. in_ready goes to 0 on the next cycle.
//  - out_ready=1 with SK full: OR <= SK, SK empties, in_ready goes to 1 on the next cycle. On that cycle
//    in_ready was 0, so there is no input transfer.
//  - Simultaneous input transfer and output transfer with SK empty: OR loads the new block.
//    out_valid stays 1 and throughput is 1 block/clk.
//  - No bubbles: with out_ready held 1, every cycle with in_valid=1 produces one output block.
//  - Ordering is strictly FIFO. A block is never duplicated or dropped, except on flush or reset.
//  - flush=1: on the next edge OR and SK valid bits clear and in_ready=1. An input presented on the same
//    cycle is discarded. flush has priority over all transfers.
//  - Reset mid-operation: all held blocks are lost. Outputs return to reset values immediately.
//  - Data/tag registers load only on an accept. They hold their value when invalid and are not cleared
//    by flush.
// STRUCTURE
//  - aes_pkg (shared): AES_STATE_W=128, AES_POLY=8'h1B, function xtime(byte), function
//    shift_rows(state). The key-expansion and inverse-path stages reuse these.
//  - Sub-module mix_column: combinational 32-bit in -> 32-bit out. Instantiate it 4x.
//  - Top: shift_rows -> 4x mix_column -> mux on in_last -> OR/SK registers and control.
// TESTING
//  1. FIPS-197 App.B rnd1, in_last=0: s_in=d42711aee0bf98f1b8b45de51e415230
//     -> m_o=046681e5e0cb199a48f8d37a2806264c one cycle after accept.
//  2. Last round: s_in=00112233445566778899aabbccddeeff, in_last=1 -> m_o=0055aaff4499ee3388dd2277cc1166bb.
//  3. Column check: s_in = 4 copies of db135345, in_last=0 -> m_o = 4 copies of 8e4da1bc.
//     Also all-01 input -> all-01 output.
//  4. Backpressure: stream 8 blocks tagged 0..7, out_ready=0 for cycles 3..6.
//     -> in_ready=0 after SK fills. All 8 tags emerge in order, each exactly once, with correct data.
//  5. Throughput: in_valid=1 and out_ready=1 for 16 cycles -> 16 outputs on consecutive cycles,
//     in_ready stays 1.
//  6. Flush and reset: OR+SK full, then flush=1 -> next cycle out_valid=0, in_ready=1.
//     Repeat with rst asserted mid-cycle -> out_valid=0 and m_o=0 immediately, before any clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: state width, reduction polynomial,
// GF(2^8) doubling and the ShiftRows byte permutation.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply a byte by x (i.e. by 2) in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // ShiftRows: out byte[4c+r] = in byte[4((c+r)%4)+r]; byte 0 is the MSB byte.
  function automatic logic [AES_STATE_W-1:0] shift_rows(input logic [AES_STATE_W-1:0] st);
    logic [AES_STATE_W-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mix_column.sv
// MixColumns on a single 32-bit column; row 0 is the most significant byte.
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  // Matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2], where 3*a = xtime(a)^a.
  always_comb begin
    o_col = '0;
    o_col[31:24] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    o_col[23:16] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    o_col[7:0]   = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

endmodule

// File: rtl/shift_mix_stage.sv
// AES round stage: ShiftRows then MixColumns (ShiftRows only on the last
// round), registered with a one-entry skid buffer so in_ready is a flop.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both 1;
// the producer holds data stable while valid && !ready, and valid never
// depends on ready.
module shift_mix_stage
  import aes_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] s_in,
  input  logic                   in_last,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] m_o,
  output logic [TAG_W-1:0]       out_tag
);

  logic [AES_STATE_W-1:0] w_sr;
  logic [AES_STATE_W-1:0] w_mc;
  logic [AES_STATE_W-1:0] w_xform;

  logic                   r_or_valid;
  logic [AES_STATE_W-1:0] r_or_data;
  logic [TAG_W-1:0]       r_or_tag;
  logic                   r_sk_valid;
  logic [AES_STATE_W-1:0] r_sk_data;
  logic [TAG_W-1:0]       r_sk_tag;
  logic                   r_in_ready;

  logic w_in_fire;
  logic w_to_or;
  logic w_to_sk;
  logic w_sk_drain;

  assign w_sr = shift_rows(s_in);

  genvar gc;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_mix
      mix_column u_mix_column (
        .i_col (w_sr[127-32*gc -: 32]),
        .o_col (w_mc[127-32*gc -: 32])
      );
    end
  endgenerate

  assign w_xform = in_last ? w_sr : w_mc;

  // While SK is full in_ready is 0, so an input accept and an SK drain are
  // mutually exclusive; flush suppresses every transfer.
  assign w_in_fire  = in_valid & r_in_ready & ~flush;
  assign w_to_or    = w_in_fire & (~r_or_valid | out_ready);
  assign w_to_sk    = w_in_fire & r_or_valid & ~out_ready;
  assign w_sk_drain = ~flush & r_sk_valid & out_ready;

  // Valid bits and the registered ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_or_valid <= 1'b0;
      r_sk_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_or_valid <= 1'b0;
      r_sk_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (r_sk_valid) begin
      if (out_ready) begin
        r_sk_valid <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end else if (w_to_sk) begin
      r_sk_valid <= 1'b1;
      r_in_ready <= 1'b0;
    end else if (w_to_or) begin
      r_or_valid <= 1'b1;
    end else if (r_or_valid && out_ready) begin
      r_or_valid <= 1'b0;
    end
  end

  // Payload registers load only on an accept or an SK-to-OR move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_or_data <= '0;
      r_or_tag  <= '0;
      r_sk_data <= '0;
      r_sk_tag  <= '0;
    end else begin
      if (w_sk_drain) begin
        r_or_data <= r_sk_data;
        r_or_tag  <= r_sk_tag;
      end else if (w_to_or) begin
        r_or_data <= w_xform;
        r_or_tag  <= in_tag;
      end
      if (w_to_sk) begin
        r_sk_data <= w_xform;
        r_sk_tag  <= in_tag;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_or_valid;
  assign m_o       = r_or_data;
  assign out_tag   = r_or_tag;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Bench for shift_mix_stage: known-answer vector table, backpressure,
// throughput, flush/reset sequences and a randomized run against a
// reference model built from GF(2^8) arithmetic.
module tb_shift_mix_stage;

  localparam int TAG_W = 4;
  localparam int W = 128 + TAG_W;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [127:0]       s_in;
  logic               in_last;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [127:0]       m_o;
  logic [TAG_W-1:0]   out_tag;

  shift_mix_stage #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .in_last   (in_last),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m_o       (m_o),
    .out_tag   (out_tag)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  int cyc = 0;
  int out_count = 0;
  int first_out_cyc = -1;
  int last_out_cyc = -1;
  bit saw_ready_low = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    p = 8'h00;
    aa = {1'b0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11B;
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic last);
    logic [7:0] b[16];
    logic [7:0] sr[16];
    logic [7:0] o[16];
    int m[4][4];
    logic [127:0] res;
    m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    for (int k = 0; k < 16; k++) b[k] = s[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[4*c+r] = 8'h00;
        for (int k = 0; k < 4; k++) o[4*c+r] = o[4*c+r] ^ gmul(8'(m[r][k]), sr[4*c+k]);
      end
    res = '0;
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = last ? sr[k] : o[k];
    return res;
  endfunction

  // ---------------- monitor (samples mid-cycle) ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_count++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out: got tag %0d data %h, expected no output", out_tag, m_o);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_o, e[127:0]);
          check("out_tag", 128'(out_tag), 128'(e[W-1:128]));
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back({in_tag, model(s_in, in_last)});
      if (!in_ready) saw_ready_low = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [127:0] d, input logic l, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    s_in = d; in_last = l; in_tag = t; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] s;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];
  bit rand_done;

  initial begin
    vecs[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};
    vecs[1] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h0055aaff4499ee3388dd2277cc1166bb};
    vecs[2] = '{{4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}};
    vecs[3] = '{{16{8'h01}}, 1'b0, {16{8'h01}}};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; s_in = '0; in_last = 1'b0;
    in_tag = '0; out_ready = 1'b0;
    #12;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_in_ready", 128'(in_ready), 128'd1);
    check("reset_m_o", m_o, 128'd0);
    check("reset_out_tag", 128'(out_tag), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Known-answer vectors: result visible one cycle after accept.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].s, vecs[i].last, TAG_W'(i));
      check($sformatf("vec%0d_valid", i), 128'(out_valid), 128'd1);
      check($sformatf("vec%0d_data", i), m_o, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 128'(out_tag), 128'(i));
    end
    idle(3);

    // Backpressure: 8 tagged blocks, out_ready low for cycles 3..6.
    out_count = 0; saw_ready_low = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand128(), 1'($urandom_range(0, 1)), TAG_W'(i));
      end
      begin
        for (int k = 0; k < 12; k++) begin
          out_ready = !(k >= 3 && k <= 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(5);
    check("bp_out_count", 128'(out_count), 128'd8);
    check("bp_queue_empty", 128'(exp_q.size()), 128'd0);
    check("bp_ready_dropped", 128'(saw_ready_low), 128'd1);

    // Throughput: 16 back-to-back blocks with out_ready held high.
    out_count = 0; saw_ready_low = 0; first_out_cyc = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(rand128(), 1'($urandom_range(0, 1)), TAG_W'(i));
    idle(3);
    check("tp_out_count", 128'(out_count), 128'd16);
    check("tp_consecutive", 128'(last_out_cyc - first_out_cyc), 128'd15);
    check("tp_ready_high", 128'(saw_ready_low), 128'd0);

    // Flush with OR and SK full; input on the flush cycle is discarded.
    out_ready = 1'b0;
    send(vecs[0].s, 1'b0, 4'd9);
    send(vecs[1].s, 1'b1, 4'd10);
    check("fl_ready_low", 128'(in_ready), 128'd0);
    flush = 1'b1; in_valid = 1'b1; s_in = vecs[2].s; in_tag = 4'd11;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 128'(out_valid), 128'd0);
    check("fl_in_ready", 128'(in_ready), 128'd1);
    check("fl_data_held", m_o, vecs[0].exp);
    out_ready = 1'b1;
    idle(3);
    check("fl_no_output", 128'(out_valid), 128'd0);

    // Asynchronous reset mid-cycle with OR and SK full.
    out_ready = 1'b0;
    send(vecs[2].s, 1'b0, 4'd12);
    send(vecs[3].s, 1'b0, 4'd13);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_m_o", m_o, 128'd0);
    check("rst_out_tag", 128'(out_tag), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Randomized traffic with random backpressure and idle gaps.
    out_count = 0; rand_done = 0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(rand128(), 1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 15)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    idle(5);
    check("rand_out_count", 128'(out_count), 128'd150);
    check("rand_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
